// File: rtl/key_serializer.sv
// Serialises a 5-bit key frame {MODE, SECRET[3:0]}, MODE first, one bit per
// ValidCmd pulse with optional idle gaps between bits. All outputs registered.
module key_serializer #(
  parameter logic [3:0] SECRET     = 4'b0101,
  parameter int         GAP_CYCLES = 0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic ModeIn,
  input  logic Abort,
  output logic ValidCmd,
  output logic InputKey,
  output logic Busy,
  output logic Done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [2:0] LAST_BIT = 3'd4;

  state_t     stateReg, stateNext;
  logic [4:0] shiftReg, shiftNext;
  logic [2:0] bitCntReg, bitCntNext;
  logic [3:0] gapCntReg, gapCntNext;
  logic       validNext, keyNext, busyNext, doneNext;

  always_comb begin
    stateNext  = stateReg;
    shiftNext  = shiftReg;
    bitCntNext = bitCntReg;
    gapCntNext = gapCntReg;

    case (stateReg)
      IDLE: begin
        if (Start && !Abort) begin
          shiftNext  = {ModeIn, SECRET};
          bitCntNext = 3'd0;
          gapCntNext = 4'd0;
          stateNext  = SEND;
        end
      end
      SEND: begin
        if (Abort) begin
          stateNext = IDLE;
        end else if (bitCntReg == LAST_BIT) begin
          stateNext = DONE;
        end else begin
          // Shift on leaving SEND so shiftReg[4] already holds the next bit.
          shiftNext  = {shiftReg[3:0], 1'b0};
          bitCntNext = bitCntReg + 3'd1;
          gapCntNext = 4'd0;
          stateNext  = (GAP_CYCLES > 0) ? GAP : SEND;
        end
      end
      GAP: begin
        if (Abort) begin
          stateNext = IDLE;
        end else if (gapCntReg == GAP_LAST) begin
          stateNext = SEND;
        end else begin
          gapCntNext = gapCntReg + 4'd1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    validNext = (stateNext == SEND);
    keyNext   = validNext & shiftNext[4];
    busyNext  = (stateNext == SEND) || (stateNext == GAP);
    doneNext  = (stateNext == DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg  <= IDLE;
      shiftReg  <= 5'd0;
      bitCntReg <= 3'd0;
      gapCntReg <= 4'd0;
      ValidCmd  <= 1'b0;
      InputKey  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      shiftReg  <= shiftNext;
      bitCntReg <= bitCntNext;
      gapCntReg <= gapCntNext;
      ValidCmd  <= validNext;
      InputKey  <= keyNext;
      Busy      <= busyNext;
      Done      <= doneNext;
    end
  end

endmodule

// File: tb/tb_key_serializer.sv
// Bench for key_serializer: two instances (no gap, 2-cycle gap) on shared inputs,
// a directed vector table, hand-written gap/reset sequences and random traffic.
module tb_key_serializer;

  localparam logic [3:0] SECRET = 4'b0101;
  localparam int GAP_A = 0;
  localparam int GAP_B = 2;

  // Output record: {ValidCmd, InputKey, Busy, Done}
  typedef struct packed {
    logic v;
    logic k;
    logic b;
    logic d;
  } outs_t;

  typedef struct {
    logic start;
    logic mode;
    logic abort;
    logic [3:0] exp;
  } vec_t;

  logic Clk, Reset, Start, ModeIn, Abort;
  logic validA, keyA, busyA, doneA;
  logic validB, keyB, busyB, doneB;
  outs_t actA, actB;

  int nChecks = 0;
  int nFails  = 0;

  outs_t q [2][$];
  outs_t cur [2];
  vec_t  vecs [$];

  key_serializer #(.SECRET(SECRET), .GAP_CYCLES(GAP_A)) dutA (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ModeIn(ModeIn), .Abort(Abort),
    .ValidCmd(validA), .InputKey(keyA), .Busy(busyA), .Done(doneA)
  );

  key_serializer #(.SECRET(SECRET), .GAP_CYCLES(GAP_B)) dutB (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ModeIn(ModeIn), .Abort(Abort),
    .ValidCmd(validB), .InputKey(keyB), .Busy(busyB), .Done(doneB)
  );

  assign actA = {validA, keyA, busyA, doneA};
  assign actB = {validB, keyB, busyB, doneB};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got vkbd=%b, expected vkbd=%b at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: an accepted frame becomes a queue of per-cycle output records.
  task automatic modelEdge();
    logic [4:0] frame;
    int gap;
    for (int u = 0; u < 2; u++) begin
      gap = (u == 0) ? GAP_A : GAP_B;
      if (!Reset) begin
        q[u].delete();
        cur[u] = '0;
      end else if (cur[u].b && Abort) begin
        q[u].delete();
        cur[u] = '0;
      end else if (q[u].size() > 0) begin
        cur[u] = q[u].pop_front();
      end else if (!cur[u].b && !cur[u].d && Start && !Abort) begin
        frame = {ModeIn, SECRET};
        for (int i = 0; i < 5; i++) begin
          q[u].push_back({1'b1, frame[4-i], 1'b1, 1'b0});
          if (i < 4)
            for (int g = 0; g < gap; g++) q[u].push_back(4'b0010);
        end
        q[u].push_back(4'b0001);
        cur[u] = q[u].pop_front();
      end else begin
        cur[u] = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    modelEdge();
    @(negedge Clk);
    check("modelA", actA, cur[0]);
    check("modelB", actB, cur[1]);
  endtask

  task automatic drive(input logic s, input logic m, input logic a);
    Start  = s;
    ModeIn = m;
    Abort  = a;
  endtask

  task automatic addVec(input logic s, input logic m, input logic a, input logic [3:0] e);
    vec_t t;
    t.start = s; t.mode = m; t.abort = a; t.exp = e;
    vecs.push_back(t);
  endtask

  initial begin
    logic [4:0] frameB;
    logic [3:0] expB;
    int bitIdx;
    logic vB;

    // One row = inputs before an edge, expected no-gap outputs in the following cycle.
    // Mode 1 frame: 1,0,1,0,1
    addVec(1, 1, 0, 4'b1110); addVec(0, 0, 0, 4'b1010); addVec(0, 0, 0, 4'b1110);
    addVec(0, 0, 0, 4'b1010); addVec(0, 0, 0, 4'b1110); addVec(0, 0, 0, 4'b0001);
    addVec(0, 0, 0, 4'b0000);
    // Mode 0 frame, ModeIn toggled after acceptance: 0,0,1,0,1
    addVec(1, 0, 0, 4'b1010); addVec(0, 1, 0, 4'b1010); addVec(0, 1, 0, 4'b1110);
    addVec(0, 0, 0, 4'b1010); addVec(0, 0, 0, 4'b1110); addVec(0, 0, 0, 4'b0001);
    addVec(0, 0, 0, 4'b0000);
    // Abort at edge 3: three bits, then idle, no Done
    addVec(1, 1, 0, 4'b1110); addVec(0, 0, 0, 4'b1010); addVec(0, 0, 0, 4'b1110);
    addVec(0, 0, 1, 4'b0000); addVec(0, 0, 0, 4'b0000); addVec(0, 0, 0, 4'b0000);
    // Start held high across edges 0-8: second frame accepted at edge 7
    addVec(1, 1, 0, 4'b1110); addVec(1, 1, 0, 4'b1010); addVec(1, 1, 0, 4'b1110);
    addVec(1, 1, 0, 4'b1010); addVec(1, 1, 0, 4'b1110); addVec(1, 1, 0, 4'b0001);
    addVec(1, 1, 0, 4'b0000); addVec(1, 1, 0, 4'b1110); addVec(1, 1, 0, 4'b1010);
    addVec(0, 0, 0, 4'b1110); addVec(0, 0, 0, 4'b1010); addVec(0, 0, 0, 4'b1110);
    addVec(0, 0, 0, 4'b0001); addVec(0, 0, 0, 4'b0000);
    // Start and Abort together in IDLE: nothing happens
    addVec(1, 1, 1, 4'b0000); addVec(0, 0, 0, 4'b0000);

    Reset = 1'b0;
    drive(0, 0, 0);
    cur[0] = '0;
    cur[1] = '0;
    #1;
    check("resetA", actA, 4'b0000);
    check("resetB", actB, 4'b0000);
    step();
    step();
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].mode, vecs[i].abort);
      step();
      check($sformatf("vec%0d", i), actA, vecs[i].exp);
    end

    // Gap of 2: pulses in cycles 1,4,7,10,13, Busy 1-13, Done in 14.
    drive(0, 0, 1); step();
    drive(0, 0, 0); step();
    step();
    frameB = {1'b1, SECRET};
    drive(1, 1, 0);
    for (int c = 1; c <= 15; c++) begin
      step();
      drive(0, 0, 0);
      vB = (c <= 13) && ((c - 1) % 3 == 0);
      bitIdx = (c - 1) / 3;
      expB = {vB, vB && (bitIdx < 5) && frameB[4 - ((bitIdx < 5) ? bitIdx : 0)],
              (c >= 1) && (c <= 13), c == 14};
      check($sformatf("gap2 cycle%0d", c), actB, expB);
    end

    // Asynchronous reset during bit 2, then silence until a new Start.
    drive(1, 1, 0); step();
    drive(0, 0, 0); step();
    step();
    #2 Reset = 1'b0;
    #1;
    check("asyncResetA", actA, 4'b0000);
    check("asyncResetB", actB, 4'b0000);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("postReset%0d", i), {validA, validB, 2'b00}, 4'b0000);
    end

    // Start on the very first edge after release is honoured.
    #2 Reset = 1'b0;
    step();
    Reset = 1'b1;
    drive(1, 0, 0);
    step();
    check("startAfterRelease", actA, 4'b1010);
    drive(0, 0, 0);
    for (int i = 0; i < 16; i++) step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
      step();
    end
    Reset = 1'b1;
    drive(0, 0, 0);
    for (int i = 0; i < 20; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/key_serializer.md
KEY_SERIALIZER -- requirements
Module: key_serializer

Interface
REQ-001 Parameter SECRET, default 4'b0101: secret phrase carried in frame bits 3:0.
REQ-002 Parameter GAP_CYCLES, default 0, legal range 0..15: idle cycles inserted after each frame bit except the last.
REQ-003 Port Clk  input  1  single clock for all state; all flops on the rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 Port Start  input  1  request to transmit one key frame; sampled only in IDLE.
REQ-006 Port ModeIn  input  1  MODE value for the frame; captured on the accepting Start edge.
REQ-007 Port Abort  input  1  cancels a frame in progress.
REQ-008 Port ValidCmd  output  1  high for exactly one cycle per transmitted frame bit.
REQ-009 Port InputKey  output  1  frame bit value, qualified by ValidCmd.
REQ-010 Port Busy  output  1  frame transmission in progress.
REQ-011 Port Done  output  1  one-cycle pulse marking normal frame completion.

Function
REQ-012 The frame SHALL be 5 bits, {MODE, SECRET[3], SECRET[2], SECRET[1], SECRET[0]}, sent in that order (MODE first).
REQ-013 The FSM SHALL have states IDLE, SEND, GAP and DONE.
REQ-014 IDLE: on an edge with Start=1 and Abort=0, the block SHALL latch {ModeIn, SECRET} into a 5-bit shift register, clear the bit counter, and go to SEND.
REQ-015 Latency: a Start accepted at edge N SHALL produce ValidCmd=1 with InputKey=MODE in the cycle following edge N.
REQ-016 SEND: ValidCmd SHALL be 1 and InputKey the current frame bit for one cycle.
- Next state after bits 0..3: GAP if GAP_CYCLES>0, else SEND.
- Next state after bit 4: DONE.
REQ-017 GAP: ValidCmd=0 and InputKey=0 for exactly GAP_CYCLES cycles, then SEND with the next bit; gap counter width SHALL hold 15.
REQ-018 DONE: Done=1 and Busy=0 for exactly one cycle, then IDLE unconditionally.
REQ-019 Busy SHALL be 1 in SEND and GAP, and 0 in IDLE and DONE.
REQ-020 All outputs SHALL be registered.
- InputKey SHALL be 0 whenever ValidCmd=0.
REQ-021 Start while Busy=1 or during the DONE cycle SHALL be ignored, with no queuing.
REQ-022 ModeIn changes after acceptance SHALL NOT affect the frame in flight.
REQ-023 Abort=1 on any edge while in SEND or GAP SHALL force IDLE.
- Next cycle: ValidCmd=0, Busy=0, Done=0.
- No further bits are sent.
REQ-024 Abort=1 and Start=1 on the same edge in IDLE SHALL leave the block in IDLE (Abort wins).
REQ-025 The bit counter SHALL be 3 bits, count 0..4, and never wrap within a frame.

Reset
REQ-026 Reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, clear the counters and shift register, and drive ValidCmd, InputKey, Busy and Done to 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for a new Start.
REQ-028 Start accepted on the first edge after Reset release SHALL be honoured normally.

Verification
REQ-029 GAP_CYCLES=0, ModeIn=1, Start pulsed at edge 0 -> ValidCmd=1 in cycles 1-5; InputKey 1,0,1,0,1; Busy=1 in cycles 1-5; Done=1 in cycle 6 only.
REQ-030 GAP_CYCLES=0, ModeIn=0 -> InputKey 0,0,1,0,1 in cycles 1-5; Done in cycle 6.
REQ-031 GAP_CYCLES=2, ModeIn=1, Start at edge 0 -> ValidCmd=1 only in cycles 1, 4, 7, 10, 13; Busy=1 in cycles 1-13; Done in cycle 14.
REQ-032 GAP_CYCLES=0, Abort=1 at edge 3 -> bits sent in cycles 1-3 only; cycle 4: ValidCmd=0, Busy=0; Done never asserted.
REQ-033 Start held high throughout cycles 0-8, GAP_CYCLES=0 -> frame in cycles 1-5, Done in cycle 6, second frame starting cycle 8 (accepted at edge 7).
- Start=1 and Abort=1 together in IDLE -> no ValidCmd pulse.
REQ-034 Reset driven low mid-cycle during bit 2 -> all outputs 0 before the next edge.
- After release, no ValidCmd until a new Start.
